// File: rtl/cdc_sync_pkg.sv
// Shared clock-domain-crossing constants used by every synchronizer in the design.
package cdc_sync_pkg;

    localparam int   CDC_STAGES_DEFAULT = 5;
    localparam logic CDC_INIT_DEFAULT   = 1'b0;
    localparam int   CDC_STAGES_MIN     = 2;
    localparam int   CDC_STAGES_MAX     = 8;

    function automatic bit stagesLegal(input int stages);
        return (stages >= CDC_STAGES_MIN) && (stages <= CDC_STAGES_MAX);
    endfunction

endpackage

// File: rtl/cdc_sync_ff_chain.sv
// Single-bit flop chain used as a metastability synchronizer into the clk domain.
module sync_ff_chain
    import cdc_sync_pkg::*;
#(
    parameter int   STAGES = CDC_STAGES_DEFAULT,
    parameter logic INIT   = CDC_INIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    // Pure shift register: nothing may sit between stages, and the tools must keep every flop.
    (* ASYNC_REG = "TRUE", dont_touch = "true" *)
    logic [STAGES-1:0] r_chain = {STAGES{INIT}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= {STAGES{INIT}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/cdc_sync.sv
// Per-bit level synchronizers plus rising-edge strobe regeneration for async done/strobe inputs.
module cdc_sync
    import cdc_sync_pkg::*;
#(
    parameter int   WIDTH  = 1,
    parameter int   STAGES = CDC_STAGES_DEFAULT,
    parameter logic INIT   = CDC_INIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    input  logic [WIDTH-1:0] pulse_i,
    output logic [WIDTH-1:0] pulse_o
);

    logic [WIDTH-1:0] w_levelSync;
    logic [WIDTH-1:0] w_pulseSync;
    logic [WIDTH-1:0] r_pulsePrev = '0;
    logic [WIDTH-1:0] r_pulseOut  = '0;

    for (genvar k = 0; k < WIDTH; k++) begin : g_bit
        sync_ff_chain #(
            .STAGES(STAGES),
            .INIT  (INIT)
        ) u_level (
            .clk(clk),
            .rst(rst),
            .i_d(data_in[k]),
            .o_q(w_levelSync[k])
        );

        sync_ff_chain #(
            .STAGES(STAGES),
            .INIT  (1'b0)
        ) u_pulse (
            .clk(clk),
            .rst(rst),
            .i_d(pulse_i[k]),
            .o_q(w_pulseSync[k])
        );
    end

    // Registered rising-edge detect on the synchronized strobe; prev follows the chain output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pulsePrev <= '0;
            r_pulseOut  <= '0;
        end else begin
            r_pulsePrev <= w_pulseSync;
            r_pulseOut  <= w_pulseSync & ~r_pulsePrev;
        end
    end

    assign data_out = w_levelSync;
    assign pulse_o  = r_pulseOut;

endmodule

// File: tb/tb_cdc_sync.sv
// Directed bench for cdc_sync: level latency, strobe generation, reset and per-bit independence.
module tb_cdc_sync;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Default instance: WIDTH=1, STAGES=5, INIT=0, reset tied low.
    logic       rstDef    = 1'b0;
    logic       dataInDef = 1'b0;
    logic       pulseIDef = 1'b0;
    logic       dataOutDef;
    logic       pulseODef;

    // INIT=1 instance used for the reset scenario.
    logic       rstI1     = 1'b1;
    logic       dataInI1  = 1'b0;
    logic       pulseII1  = 1'b1;
    logic       dataOutI1;
    logic       pulseOI1;

    // Four-bit instance for per-bit independence, reset tied low.
    logic       rstW4     = 1'b0;
    logic [3:0] dataInW4  = 4'b1011;
    logic [3:0] pulseIW4  = 4'b0000;
    logic [3:0] dataOutW4;
    logic [3:0] pulseOW4;

    cdc_sync u_def (
        .clk(clock), .rst(rstDef),
        .data_in(dataInDef), .data_out(dataOutDef),
        .pulse_i(pulseIDef), .pulse_o(pulseODef)
    );

    cdc_sync #(.WIDTH(1), .STAGES(5), .INIT(1'b1)) u_init1 (
        .clk(clock), .rst(rstI1),
        .data_in(dataInI1), .data_out(dataOutI1),
        .pulse_i(pulseII1), .pulse_o(pulseOI1)
    );

    cdc_sync #(.WIDTH(4), .STAGES(5), .INIT(1'b0)) u_w4 (
        .clk(clock), .rst(rstW4),
        .data_in(dataInW4), .data_out(dataOutW4),
        .pulse_i(pulseIW4), .pulse_o(pulseOW4)
    );

    // Advance one rising edge and settle 1 time unit past it before sampling or driving.
    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        // Power-up values before any clock edge.
        #1;
        checkOutput("powerup_def_data",  {3'b0, dataOutDef}, 4'h0);
        checkOutput("powerup_def_pulse", {3'b0, pulseODef},  4'h0);
        checkOutput("powerup_i1_data",   {3'b0, dataOutI1},  4'h1);
        checkOutput("powerup_i1_pulse",  {3'b0, pulseOI1},   4'h0);

        // Hold u_init1 in reset for three edges with pulse_i high and data_in low.
        for (int n = 1; n <= 3; n++) begin
            applyStimulus();
            checkOutput($sformatf("rst_i1_data_e%0d", n),  {3'b0, dataOutI1}, 4'h1);
            checkOutput($sformatf("rst_i1_pulse_e%0d", n), {3'b0, pulseOI1},  4'h0);
            checkOutput($sformatf("idle_def_data_e%0d", n),  {3'b0, dataOutDef}, 4'h0);
            checkOutput($sformatf("idle_def_pulse_e%0d", n), {3'b0, pulseODef},  4'h0);
        end
        rstI1 = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            applyStimulus();
            checkOutput($sformatf("rel_i1_data_e%0d", n),  {3'b0, dataOutI1}, (n >= 5) ? 4'h0 : 4'h1);
            checkOutput($sformatf("rel_i1_pulse_e%0d", n), {3'b0, pulseOI1},  (n == 6) ? 4'h1 : 4'h0);
        end

        // Level path: data_out rises on the fifth edge after data_in rises.
        dataInDef = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            applyStimulus();
            checkOutput($sformatf("lvl_rise_e%0d", n), {3'b0, dataOutDef}, (n >= 5) ? 4'h1 : 4'h0);
        end
        dataInDef = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            applyStimulus();
            checkOutput($sformatf("lvl_fall_e%0d", n), {3'b0, dataOutDef}, (n >= 5) ? 4'h0 : 4'h1);
        end

        // Single pulse held high for four cycles: one strobe on edge 6.
        pulseIDef = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            applyStimulus();
            if (n == 4) pulseIDef = 1'b0;
            checkOutput($sformatf("pls_single_e%0d", n), {3'b0, pulseODef}, (n == 6) ? 4'h1 : 4'h0);
        end

        // Back-to-back: 3 high, 3 low, 3 high gives strobes at edges 6 and 12.
        pulseIDef = 1'b1;
        for (int n = 1; n <= 18; n++) begin
            applyStimulus();
            if (n == 3) pulseIDef = 1'b0;
            if (n == 6) pulseIDef = 1'b1;
            if (n == 9) pulseIDef = 1'b0;
            checkOutput($sformatf("pls_b2b_e%0d", n), {3'b0, pulseODef},
                        (n == 6 || n == 12) ? 4'h1 : 4'h0);
        end

        // Four-bit instance: only bit 2 changes; the other bits must hold 1011 / 0000.
        checkOutput("w4_steady_data",  dataOutW4, 4'b1011);
        checkOutput("w4_steady_pulse", pulseOW4,  4'b0000);
        dataInW4 = 4'b1111;
        pulseIW4 = 4'b0100;
        for (int n = 1; n <= 10; n++) begin
            applyStimulus();
            if (n == 4) pulseIW4 = 4'b0000;
            checkOutput($sformatf("w4_data_e%0d", n),  dataOutW4, (n >= 5) ? 4'b1111 : 4'b1011);
            checkOutput($sformatf("w4_pulse_e%0d", n), pulseOW4,  (n == 6) ? 4'b0100 : 4'b0000);
        end
        dataInW4 = 4'b1011;
        for (int n = 1; n <= 7; n++) begin
            applyStimulus();
            checkOutput($sformatf("w4_fall_e%0d", n), dataOutW4, (n >= 5) ? 4'b1011 : 4'b1111);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
